// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_checker
// Brief    : Avalon-MM master that reads the sysid ID/timestamp words and
//            flags whether the loaded image matches the expected build.
//            Optional read watchdog enabled by defining SYSID_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5E29_78C1,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ID  = 3'd1,
        S_GAP_ID = 3'd2,
        S_RD_TS  = 3'd3,
        S_GAP_TS = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
    logic [31:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
    logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, pass_q, pass_d;
    logic        aborted_q, aborted_d, timeout_q, timeout_d;
    logic        accept;
    logic        expire;

    assign accept = rd_q & ~avm_waitrequest;

`ifdef SYSID_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Counter sits at zero whenever no read is outstanding, so each read starts fresh.
    always_comb begin
        wait_cnt_d = '0;
        expire     = 1'b0;
        if (rd_q && avm_waitrequest) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
            expire     = (wait_cnt_d == TIMEOUT_LIMIT);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wait_cnt_q <= '0;
        else          wait_cnt_q <= wait_cnt_d;
    end
`else
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cap_id_d   = cap_id_q;
        cap_ts_d   = cap_ts_q;
        aborted_d  = aborted_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RD_ID;
                    rd_d      = 1'b1;
                    addr_d    = 1'b0;
                    busy_d    = 1'b1;
                    cap_id_d  = '0;
                    cap_ts_d  = '0;
                    aborted_d = 1'b0;
                end
            end
            S_RD_ID: begin
                if (accept) begin
                    cap_id_d = avm_readdata;
                    rd_d     = 1'b0;
                    state_d  = S_GAP_ID;
                end else if (expire) begin
                    rd_d      = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = S_GAP_TS;
                end
            end
            S_GAP_ID: begin
                rd_d    = 1'b1;
                addr_d  = 1'b1;
                state_d = S_RD_TS;
            end
            S_RD_TS: begin
                if (accept) begin
                    cap_ts_d = avm_readdata;
                    rd_d     = 1'b0;
                    addr_d   = 1'b0;
                    state_d  = S_GAP_TS;
                end else if (expire) begin
                    rd_d      = 1'b0;
                    addr_d    = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = S_GAP_TS;
                end
            end
            S_GAP_TS: begin
                // Results are published together so they only change at DONE.
                state_d    = S_DONE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                id_value_d = cap_id_q;
                ts_value_d = cap_ts_q;
                id_ok_d    = (cap_id_q == EXPECTED_ID);
                ts_ok_d    = (cap_ts_q == EXPECTED_TS);
                timeout_d  = aborted_q;
                pass_d     = id_ok_d & (ts_ok_d | ~CHECK_TS) & ~aborted_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cap_id_q   <= '0;
            cap_ts_q   <= '0;
            aborted_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cap_id_q   <= cap_id_d;
            cap_ts_q   <= cap_ts_d;
            aborted_q  <= aborted_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    assign avm_read    = rd_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_checker
// Brief    : Directed vector bench for sysid_checker (two instances: CHECK_TS=1/0).
// Revision : 1.0
// ============================================================================
module tb_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'h5E29_78C1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, pass, timeout;
    logic [31:0] id_value, ts_value;

    logic        avm_address_b, avm_read_b, busy_b, done_b;
    logic        id_ok_b, ts_ok_b, pass_b, timeout_b;
    logic [31:0] avm_readdata_b, id_value_b, ts_value_b;

    logic [31:0] id_word = '0;
    logic [31:0] ts_word = '0;
    int          stall_n = 0;
    int          stall_cnt = 0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_id = '0;

    always #5 clock = ~clock;

    // Slave model: stalls each read for stall_n cycles, then returns the addressed word.
    assign avm_waitrequest = avm_read && (stall_cnt < stall_n);
    assign avm_readdata    = avm_address   ? ts_word : id_word;
    assign avm_readdata_b  = avm_address_b ? ts_word : id_word;

    always @(posedge clock) begin
        if (!reset_n)      stall_cnt <= 0;
        else if (avm_read) stall_cnt <= avm_waitrequest ? stall_cnt + 1 : 0;
    end

    sysid_checker #(
        .EXPECTED_ID(32'h0000_0000), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .id_value(id_value), .ts_value(ts_value),
        .id_ok(id_ok), .ts_ok(ts_ok), .pass(pass), .timeout(timeout)
    );

    sysid_checker #(
        .EXPECTED_ID(32'h0000_0000), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address_b), .avm_read(avm_read_b),
        .avm_readdata(avm_readdata_b), .avm_waitrequest(avm_waitrequest),
        .busy(busy_b), .done(done_b), .id_value(id_value_b), .ts_value(ts_value_b),
        .id_ok(id_ok_b), .ts_ok(ts_ok_b), .pass(pass_b), .timeout(timeout_b)
    );

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        int          stall_n;
        int          exp_cycle;
        logic        exp_id_ok;
        logic        exp_ts_ok;
        logic        exp_pass;
        logic        exp_pass_nots;
        int          mid_start;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        bit   seen;
        int   viol;
        logic p_stall, p_acc, p_addr;
        stall_n = v.stall_n;
        id_word = v.id_word;
        ts_word = v.ts_word;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        check("start_resp", {61'd0, busy, avm_read, avm_address}, 64'b110);
        check("results_hold", {32'd0, id_value}, {32'd0, last_id});
        seen = 1'b0; viol = 0; p_stall = 1'b0; p_acc = 1'b0; p_addr = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) viol++;
                if (p_stall && !(avm_read && avm_address == p_addr)) viol++;
                if (p_acc && avm_read) viol++;
                p_stall = avm_read && avm_waitrequest;
                p_acc   = avm_read && !avm_waitrequest;
                p_addr  = avm_address;
                start   = (cyc == v.mid_start);
                @(negedge clock);
                start = 1'b0;
                cyc++;
            end
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("done_cycle", 64'(cyc), 64'(v.exp_cycle));
        check("protocol", 64'(viol), 64'd0);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("id_value", {32'd0, id_value}, {32'd0, v.id_word});
        check("ts_value", {32'd0, ts_value}, {32'd0, v.ts_word});
        check("flags", {60'd0, id_ok, ts_ok, pass, timeout},
              {60'd0, v.exp_id_ok, v.exp_ts_ok, v.exp_pass, 1'b0});
        check("flags_nots", {62'd0, ts_ok_b, pass_b}, {62'd0, v.exp_ts_ok, v.exp_pass_nots});
        // A start coinciding with done must not launch a new check.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_at_done", {61'd0, busy, avm_read, done}, 64'd0);
        last_id = v.id_word;
    endtask

    initial begin
        int cyc;
        bit seen;

        vecs[0] = '{32'h0000_0000, EXP_TS,        0, 5,  1'b1, 1'b1, 1'b1, 1'b1, 0};
        vecs[1] = '{32'h0000_0001, EXP_TS,        0, 5,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 0, 5,  1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h5E29_78C0, 1, 7,  1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 2, 9,  1'b1, 1'b0, 1'b0, 1'b1, 0};
        vecs[5] = '{32'h0000_0000, EXP_TS,        3, 11, 1'b1, 1'b1, 1'b1, 1'b1, 3};

        repeat (3) @(negedge clock);
        check("reset_outputs",
              {busy, avm_read, avm_address, done, id_ok, ts_ok, pass, timeout, id_value, ts_value},
              72'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {60'd0, busy, avm_read, done, pass}, 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while the timestamp read is outstanding.
        stall_n = 2;
        id_word = 32'h0000_0001;
        ts_word = EXP_TS;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (avm_read && avm_address) seen = 1'b1;
            else @(negedge clock);
        end
        check("reach_rd_ts", {63'd0, seen}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_bus", {62'd0, avm_read, busy}, 64'd0);
        check("async_reset_results",
              {done, id_ok, ts_ok, pass, timeout, id_value, ts_value}, 69'd0);
        @(negedge clock);
        reset_n = 1'b1;
        last_id = '0;
        run_vec(vecs[0]);

`ifdef SYSID_TIMEOUT_EN
        // Slave never releases waitrequest; watchdog budget is 8 cycles.
        stall_n = 1000;
        id_word = 32'h1234_5678;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (done) seen = 1'b1;
            else begin
                if (cyc == 9) check("to_read_dropped", {63'd0, avm_read}, 64'd0);
                @(negedge clock);
                cyc++;
            end
        end
        check("to_done_seen", {63'd0, seen}, 64'd1);
        check("to_done_cycle", 64'(cyc), 64'd10);
        check("to_flags", {62'd0, timeout, pass}, 64'b10);
        check("to_values", {id_value, ts_value}, 64'd0);
        stall_n = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
